// File: rtl/risc_pkg.sv
// risc_pkg: shared RV32 decode constants, bundles and the aluOp encoding.
// Bundle layout of decoded_t depends on INST_DECODER_ILLEGAL_TRAP_EN.
package risc_pkg;

    localparam int cXLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [5:0] TYPE_R = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_B = 6'b001000;
    localparam logic [5:0] TYPE_U = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        ALU_AUIPC
    } aluOp_e;

    typedef struct packed {
        logic             valid;
        logic [5:0]       instType;
        logic [6:0]       opcode;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       f3;
        logic [6:0]       f7;
        logic [cXLEN-1:0] imm;
        logic [cXLEN-1:0] pc;
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
        logic             illegal;
`endif
    } decoded_t;

    typedef struct packed {
        logic       load;
        logic       store;
        logic [2:0] size;
        logic [4:0] rd;
    } memOp_t;

    typedef struct packed {
        aluOp_e     aluOp;
        logic       useImm;
        logic       writeRd;
        logic [4:0] rd;
    } regOp_t;

    typedef struct packed {
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] cond;
    } branchOp_t;

    // SUB only exists in the register form; f7[5] selects SRA in both forms
    function automatic aluOp_e alu_sel(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       isReg
    );
        aluOp_e op;
        unique case (f3)
            3'd0: op = (isReg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate for the RV32 base formats.
// R-type and unknown opcodes yield zero.
module imm_gen
    import risc_pkg::*;
(
    input  logic [cXLEN-1:0] iInst,
    output logic [cXLEN-1:0] oImm
);

    always_comb begin
        oImm = '0;
        unique case (iInst[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                oImm = {{20{iInst[31]}}, iInst[31:20]};
            OPC_STORE:
                oImm = {{20{iInst[31]}}, iInst[31:25], iInst[11:7]};
            OPC_BRANCH:
                oImm = {{19{iInst[31]}}, iInst[31], iInst[7],
                        iInst[30:25], iInst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                oImm = {iInst[31:12], 12'h000};
            OPC_JAL:
                oImm = {{11{iInst[31]}}, iInst[31], iInst[19:12],
                        iInst[20], iInst[30:21], 1'b0};
            default:
                oImm = '0;
        endcase
    end

endmodule

// File: rtl/inst_decoder.sv
// inst_decoder: RV32 decoder, one word per cycle, cycleNum-deep output pipe.
// Define INST_DECODER_ILLEGAL_TRAP_EN to add oDecoded.illegal.
module inst_decoder
    import risc_pkg::*;
#(
    parameter int cycleNum = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [cXLEN-1:0] iInst,
    input  logic [cXLEN-1:0] iCurPC,
    input  logic             iFlushPipe,
    output decoded_t         oDecoded,
    output memOp_t           oMemOp,
    output regOp_t           oRegOp,
    output branchOp_t        oBranchOp
);

    typedef struct packed {
        decoded_t  d;
        memOp_t    m;
        regOp_t    r;
        branchOp_t b;
    } stage_t;

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd;
    logic [cXLEN-1:0] immRaw;
    logic [5:0]       typ;
    aluOp_e           alu;
    stage_t           dec_d;

    stage_t [cycleNum-1:0] pipe_q;

    assign opc = iInst[6:0];
    assign f3  = iInst[14:12];
    assign f7  = iInst[31:25];
    assign rd  = iInst[11:7];

    imm_gen u_imm_gen (
        .iInst (iInst),
        .oImm  (immRaw)
    );

    always_comb begin
        typ = '0;
        alu = ALU_NONE;
        unique case (1'b1)
            opc == OPC_OP: begin
                typ = TYPE_R;
                alu = alu_sel(f3, f7[5], 1'b1);
            end
            opc == OPC_OPIMM: begin
                typ = TYPE_I;
                alu = alu_sel(f3, f7[5], 1'b0);
            end
            opc == OPC_LOAD, opc == OPC_JALR: begin
                typ = TYPE_I;
                alu = ALU_ADD;
            end
            opc == OPC_STORE: begin
                typ = TYPE_S;
                alu = ALU_ADD;
            end
            opc == OPC_BRANCH: begin
                typ = TYPE_B;
                alu = ALU_SUB;
            end
            opc == OPC_LUI: begin
                typ = TYPE_U;
                alu = ALU_LUI;
            end
            opc == OPC_AUIPC: begin
                typ = TYPE_U;
                alu = ALU_AUIPC;
            end
            opc == OPC_JAL: begin
                typ = TYPE_J;
                alu = ALU_ADD;
            end
            default: ;
        endcase
    end

`ifdef INST_DECODER_ILLEGAL_TRAP_EN
    logic badCombo;

    always_comb begin
        badCombo = 1'b0;
        case (opc)
            OPC_OP:
                badCombo = !((f7 == 7'h00) ||
                             (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            OPC_OPIMM:
                badCombo = (f3 == 3'd1 && f7 != 7'h00) ||
                           (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            OPC_LOAD:
                badCombo = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OPC_STORE:
                badCombo = (f3 > 3'd2);
            OPC_BRANCH:
                badCombo = (f3 == 3'd2) || (f3 == 3'd3);
            OPC_JALR:
                badCombo = (f3 != 3'd0);
            default:
                badCombo = 1'b0;
        endcase
    end
`endif

    always_comb begin
        dec_d = '0;

        dec_d.d.valid    = (iInst != '0);
        dec_d.d.instType = typ;
        dec_d.d.opcode   = opc;
        dec_d.d.rs1      = iInst[19:15];
        dec_d.d.rs2      = iInst[24:20];
        dec_d.d.rd       = rd;
        dec_d.d.f3       = f3;
        dec_d.d.f7       = f7;
        dec_d.d.imm      = immRaw;
        dec_d.d.pc       = iCurPC;
`ifdef INST_DECODER_ILLEGAL_TRAP_EN
        dec_d.d.illegal  = (iInst != '0) && ((typ == '0) || badCombo);
`endif

        dec_d.m.load  = (opc == OPC_LOAD);
        dec_d.m.store = (opc == OPC_STORE);
        dec_d.m.size  = (dec_d.m.load || dec_d.m.store) ? f3 : 3'd0;
        dec_d.m.rd    = rd;

        dec_d.r.aluOp   = alu;
        dec_d.r.useImm  = |(typ & (TYPE_I | TYPE_S | TYPE_U | TYPE_J));
        dec_d.r.writeRd = (|(typ & (TYPE_R | TYPE_I | TYPE_U | TYPE_J)))
                          && (rd != 5'd0);
        dec_d.r.rd      = rd;

        dec_d.b.branch = (typ == TYPE_B);
        dec_d.b.jal    = (opc == OPC_JAL);
        dec_d.b.jalr   = (opc == OPC_JALR);
        dec_d.b.cond   = dec_d.b.branch ? f3 : 3'd0;
    end

    // flush also drops the word being sampled on the same edge
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pipe_q <= '0;
        end else if (iFlushPipe) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= dec_d;
            for (int i = 1; i < cycleNum; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign oDecoded  = pipe_q[cycleNum-1].d;
    assign oMemOp    = pipe_q[cycleNum-1].m;
    assign oRegOp    = pipe_q[cycleNum-1].r;
    assign oBranchOp = pipe_q[cycleNum-1].b;

endmodule

// File: tb/tb_inst_decoder.sv
// tb_inst_decoder: directed and random stream against a behavioural model.
// Built with INST_DECODER_ILLEGAL_TRAP_EN undefined.
module tb_inst_decoder;
    import risc_pkg::*;

    localparam int CN = 2;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [31:0] iInst;
    logic [31:0] iCurPC;
    logic        iFlushPipe;
    decoded_t    oDecoded;
    memOp_t      oMemOp;
    regOp_t      oRegOp;
    branchOp_t   oBranchOp;

    typedef struct packed {
        decoded_t  d;
        memOp_t    m;
        regOp_t    r;
        branchOp_t b;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   killLeft = 0;

    inst_decoder #(.cycleNum(CN)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iInst      (iInst),
        .iCurPC     (iCurPC),
        .iFlushPipe (iFlushPipe),
        .oDecoded   (oDecoded),
        .oMemOp     (oMemOp),
        .oRegOp     (oRegOp),
        .oBranchOp  (oBranchOp)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        int          s;
        int          fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        aluOp_e      tbl[8];
        e   = '0;
        s   = w;
        op  = w[6:0];
        f3  = w[14:12];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        case (op)
            7'h33:               fmt = 0;
            7'h13, 7'h03, 7'h67: fmt = 1;
            7'h23:               fmt = 2;
            7'h63:               fmt = 3;
            7'h37, 7'h17:        fmt = 4;
            7'h6f:               fmt = 5;
            default:             fmt = -1;
        endcase
        e.d.valid    = (w != 0);
        e.d.instType = (fmt < 0) ? 6'd0 : 6'(1 << fmt);
        e.d.opcode   = op;
        e.d.rs1      = w[19:15];
        e.d.rs2      = w[24:20];
        e.d.rd       = w[11:7];
        e.d.f3       = f3;
        e.d.f7       = w[31:25];
        e.d.pc       = pc;
        case (fmt)
            1: e.d.imm = 32'(s >>> 20);
            2: e.d.imm = 32'((s >>> 25) << 5) | ((w >> 7) & 32'd31);
            3: e.d.imm = 32'((s >>> 31) << 12) | (((w >> 7) & 32'd1) << 11)
                       | (((w >> 25) & 32'd63) << 5) | (((w >> 8) & 32'd15) << 1);
            4: e.d.imm = w & 32'hFFFFF000;
            5: e.d.imm = 32'((s >>> 31) << 20) | (((w >> 12) & 32'd255) << 12)
                       | (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'd1023) << 1);
            default: e.d.imm = 32'd0;
        endcase
        if (op == 7'h33 || op == 7'h13) begin
            e.r.aluOp = tbl[f3];
            if (f3 == 3'd5 && w[30]) e.r.aluOp = ALU_SRA;
            if (op == 7'h33 && f3 == 3'd0 && w[30]) e.r.aluOp = ALU_SUB;
        end else begin
            case (op)
                7'h03, 7'h23, 7'h67, 7'h6f: e.r.aluOp = ALU_ADD;
                7'h63:   e.r.aluOp = ALU_SUB;
                7'h37:   e.r.aluOp = ALU_LUI;
                7'h17:   e.r.aluOp = ALU_AUIPC;
                default: e.r.aluOp = ALU_NONE;
            endcase
        end
        e.m.load     = (op == 7'h03);
        e.m.store    = (op == 7'h23);
        e.m.size     = (e.m.load || e.m.store) ? f3 : 3'd0;
        e.m.rd       = w[11:7];
        e.r.useImm   = (fmt == 1 || fmt == 2 || fmt == 4 || fmt == 5);
        e.r.writeRd  = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5)
                       && (w[11:7] != 5'd0);
        e.r.rd       = w[11:7];
        e.b.branch   = (fmt == 3);
        e.b.jal      = (op == 7'h6f);
        e.b.jalr     = (op == 7'h67);
        e.b.cond     = e.b.branch ? f3 : 3'd0;
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".dec"}, 256'(oDecoded),  256'(q[0].d));
        chk({tag, ".mem"}, 256'(oMemOp),    256'(q[0].m));
        chk({tag, ".reg"}, 256'(oRegOp),    256'(q[0].r));
        chk({tag, ".br"},  256'(oBranchOp), 256'(q[0].b));
    endtask

    task automatic cycle(input logic [31:0] w, input logic [31:0] pc,
                         input logic flush);
        iInst      = w;
        iCurPC     = pc;
        iFlushPipe = flush;
        @(posedge iClk);
        if (flush) begin
            foreach (q[i]) q[i] = '0;
            killLeft = CN;
        end else begin
            q.push_back(model(w, pc));
            void'(q.pop_front());
        end
        #1;
        check_all("pipe");
        if (killLeft > 0) begin
            chk("flush_kill", 256'(oDecoded.valid), 256'(1'b0));
            killLeft--;
        end
    endtask

    task automatic run_one(input logic [31:0] w, input logic [31:0] pc);
        repeat (CN) cycle(32'd0, 32'd0, 1'b0);
        cycle(w, pc, 1'b0);
        for (int k = 1; k < CN; k++) begin
            chk("latency_early", 256'(oDecoded.valid), 256'(1'b0));
            cycle(32'd0, 32'd0, 1'b0);
        end
        chk("latency_pc", 256'(oDecoded.pc), 256'(pc));
    endtask

    task automatic reset_zero(input string tag);
        chk({tag, ".dec"}, 256'(oDecoded),  256'(0));
        chk({tag, ".mem"}, 256'(oMemOp),    256'(0));
        chk({tag, ".reg"}, 256'(oRegOp),    256'(0));
        chk({tag, ".br"},  256'(oBranchOp), 256'(0));
    endtask

    initial begin
        logic [6:0]  opcs [10];
        logic [31:0] w;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};
        for (int i = 0; i < CN; i++) q.push_back('0);

        iRst       = 1'b0;
        iInst      = '0;
        iCurPC     = '0;
        iFlushPipe = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        reset_zero("reset");
        iRst = 1'b1;

        run_one(32'h002081B3, 32'h0000_1000);
        chk("add.type", 256'(oDecoded.instType), 256'(6'b000001));
        chk("add.rs1",  256'(oDecoded.rs1), 256'(5'd1));
        chk("add.rs2",  256'(oDecoded.rs2), 256'(5'd2));
        chk("add.rd",   256'(oDecoded.rd),  256'(5'd3));
        chk("add.alu",  256'(oRegOp.aluOp), 256'(ALU_ADD));

        run_one(32'hFFF00293, 32'h0000_1004);
        chk("addi.type", 256'(oDecoded.instType), 256'(6'b000010));
        chk("addi.rd",   256'(oDecoded.rd),  256'(5'd5));
        chk("addi.imm",  256'(oDecoded.imm), 256'(32'hFFFFFFFF));
        chk("addi.uimm", 256'(oRegOp.useImm), 256'(1'b1));

        run_one(32'h0020A423, 32'h0000_1008);
        chk("sw.type",  256'(oDecoded.instType), 256'(6'b000100));
        chk("sw.store", 256'(oMemOp.store), 256'(1'b1));
        chk("sw.imm",   256'(oDecoded.imm), 256'(32'd8));
        chk("sw.wrd",   256'(oRegOp.writeRd), 256'(1'b0));

        run_one(32'hFE208EE3, 32'h0000_100C);
        chk("beq.type", 256'(oDecoded.instType), 256'(6'b001000));
        chk("beq.imm",  256'(oDecoded.imm), 256'(32'hFFFFFFFC));
        chk("beq.br",   256'(oBranchOp.branch), 256'(1'b1));

        run_one(32'h123450B7, 32'h0000_1010);
        chk("lui.type", 256'(oDecoded.instType), 256'(6'b010000));
        chk("lui.imm",  256'(oDecoded.imm), 256'(32'h12345000));

        run_one(32'h008000EF, 32'h0000_1014);
        chk("jal.type", 256'(oDecoded.instType), 256'(6'b100000));
        chk("jal.rd",   256'(oDecoded.rd),  256'(5'd1));
        chk("jal.imm",  256'(oDecoded.imm), 256'(32'd8));
        chk("jal.jal",  256'(oBranchOp.jal), 256'(1'b1));

        for (int i = 0; i < 100; i++) begin
            w = $urandom();
            w[6:0] = opcs[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) w = 32'd0;
            cycle(w, $urandom(), (i == 50));
        end

        // async reset must clear a live output between clock edges
        run_one(32'h002081B3, 32'h0000_2000);
        chk("prereset.valid", 256'(oDecoded.valid), 256'(1'b1));
        iInst = 32'hFFF00293;
        #2;
        iRst = 1'b0;
        #1;
        reset_zero("async_reset");
        @(posedge iClk);
        foreach (q[i]) q[i] = '0;
        #1;
        reset_zero("reset_hold");
        iRst = 1'b1;

        run_one(32'h0020A423, 32'h0000_3000);
        chk("post_reset.store", 256'(oMemOp.store), 256'(1'b1));
        for (int i = 0; i < 20; i++) begin
            w = $urandom();
            w[6:0] = opcs[$urandom_range(0, 9)];
            cycle(w, $urandom(), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 SHALL have parameter cycleNum, default 2, meaning decode-to-output latency in clock cycles, legal range 1..4.
REQ-002 SHALL have port iClk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port iRst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iInst, input, cXLEN (32) bits: instruction word, sampled every cycle.
REQ-005 SHALL have port iCurPC, input, cXLEN bits: PC of iInst.
REQ-006 SHALL have port iFlushPipe, input, 1 bit: kills all in-flight decodes.
REQ-007 SHALL have port oDecoded, output, decoded_t: valid, instType one-hot[5:0], opcode[6:0], rs1[4:0], rs2[4:0], rd[4:0], f3[2:0], f7[6:0], imm[31:0], pc[31:0].
REQ-008 SHALL have port oMemOp, output, memOp_t: load, store, size f3[2:0], rd.
REQ-009 SHALL have port oRegOp, output, regOp_t: aluOp enum, useImm, writeRd, rd.
REQ-010 SHALL have port oBranchOp, output, branchOp_t: branch, jal, jalr, cond f3[2:0].

Function
REQ-011 SHALL encode instType one-hot as follows: R=000001; I=000010 (OP-IMM 0010011, LOAD 0000011, JALR 1100111); S=000100 (0100011); B=001000 (1100011); U=010000 (LUI 0110111, AUIPC 0010111); J=100000 (1101111).
REQ-012 SHALL treat any other opcode as illegal: instType=000000 and all op flags cleared.
REQ-013 SHALL sign-extend the immediate per format: I=inst[31:20]; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-014 SHALL form the U-format immediate as {inst[31:12],12'h0}.
REQ-015 SHALL set imm=0 for R-type.
REQ-016 SHALL pass rs1, rs2, rd, f3 and f7 through raw from the fixed bit fields regardless of type.
REQ-017 SHALL set valid=1 when iInst is non-zero; iInst==0 is a bubble with valid=0 and all flags 0.
REQ-018 SHALL present all outputs exactly cycleNum rising edges after iInst/iCurPC are sampled, fully pipelined, accepting one instruction per cycle.
REQ-019 SHALL clear valid and all flags in every pipeline stage on the next edge when iFlushPipe=1; an instruction sampled in the same cycle is also killed.
REQ-020 SHALL derive aluOp from opcode, f3 and f7[5] (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, plus LUI/AUIPC pass).
REQ-021 SHALL clear writeRd for S/B-type and for rd=0.

Reset
REQ-022 SHALL asynchronously clear all pipeline registers and outputs to zero (valid=0) while iRst=0.
REQ-023 SHALL resume decoding from the first rising edge after iRst is released.

Configuration
REQ-024 SHALL, with macro INST_DECODER_ILLEGAL_TRAP_EN defined, add oDecoded.illegal, set to 1 for non-zero iInst with an unsupported opcode or an invalid f3/f7 combination.
REQ-025 SHALL, with INST_DECODER_ILLEGAL_TRAP_EN undefined, omit the illegal field; illegal words then produce valid=1 with instType=0.

Structure
REQ-026 SHALL place cXLEN, opcode constants, instType encodings, the aluOp enum and decoded_t/memOp_t/regOp_t/branchOp_t in shared package risc_pkg.
REQ-027 SHALL implement immediate generation as sub-module imm_gen (iInst in, imm out, combinational).

Verification
REQ-028 SHALL verify 0x002081B3 (ADD x3,x1,x2) -> instType=000001, rs1=1, rs2=2, rd=3, aluOp=ADD, output after exactly cycleNum cycles.
REQ-029 SHALL verify 0xFFF00293 (ADDI x5,x0,-1) -> instType=000010, rd=5, imm=0xFFFFFFFF, useImm=1.
REQ-030 SHALL verify 0x0020A423 (SW x2,8(x1)) -> instType=000100, store=1, imm=8, writeRd=0; then 0xFE208EE3 (BEQ) -> instType=001000, imm=0xFFFFFFFC, branch=1.
REQ-031 SHALL verify 0x123450B7 (LUI) -> instType=010000, imm=0x12345000; then 0x008000EF (JAL) -> instType=100000, rd=1, imm=8, jal=1.
REQ-032 SHALL verify a 100-word random stream with iFlushPipe pulsed mid-stream -> in-flight words emerge with valid=0, following words decode normally, and the stream matches a reference model.
REQ-033 SHALL verify that asserting iRst low mid-stream clears outputs immediately without waiting for a clock edge.
